// File: rtl/div_sequencer_if.sv
// Handshake and DIV-core bus between the control unit, div_sequencer and the unsigned DIV core.
// The master modport belongs to the surrounding datapath (control unit plus DIV core); the slave modport belongs to the sequencer.
interface div_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  signed_op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] lo;
  logic [DATA_WIDTH-1:0] hi;
  logic                  div_zero;
  logic                  div_nrst;
  logic [DATA_WIDTH-1:0] div_q;
  logic [DATA_WIDTH-1:0] div_m;
  logic [DATA_WIDTH-1:0] core_q;
  logic [DATA_WIDTH-1:0] core_r;

  modport master (
    output start, signed_op, a, b, core_q, core_r,
    input  busy, done, lo, hi, div_zero, div_nrst, div_q, div_m
  );

  modport slave (
    input  start, signed_op, a, b, core_q, core_r,
    output busy, done, lo, hi, div_zero, div_nrst, div_q, div_m
  );
endinterface

// File: rtl/div_sequencer.sv
// Sequences the unsigned DIV core: it feeds magnitudes to the core, waits out the core latency and sign-corrects the results.
// Optional macro DIV_ZERO_TRAP_EN: a zero divisor bypasses the core and flags div_zero.
//
// state  | meaning
// IDLE   | waiting for start; the operands and sign flags are latched on acceptance
// LOAD   | the DIV core is held in reset while its operands are stable
// RUN    | the DIV core is released; counting DIV_LATENCY cycles
// FIX    | the captured quotient and remainder are sign-corrected into lo/hi
// DONE   | done pulse; the results are valid
module div_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIV_LATENCY = 32
) (
  input logic          clk,
  input logic          rst,
  div_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  localparam int CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_LATENCY - 1);

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         cnt;
  logic                  sq;
  logic                  sr;
  logic [DATA_WIDTH-1:0] q_cap;
  logic [DATA_WIDTH-1:0] r_cap;
  logic [DATA_WIDTH-1:0] lo_r;
  logic [DATA_WIDTH-1:0] hi_r;
  logic [DATA_WIDTH-1:0] div_q_r;
  logic [DATA_WIDTH-1:0] div_m_r;
  logic                  a_neg;
  logic                  b_neg;
  logic                  b_zero;

  assign a_neg  = bus.signed_op & bus.a[DATA_WIDTH-1];
  assign b_neg  = bus.signed_op & bus.b[DATA_WIDTH-1];
  assign b_zero = (bus.b == '0);

  always_comb begin
    state_nxt    = state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.div_nrst = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef DIV_ZERO_TRAP_EN
          state_nxt = b_zero ? S_DONE : S_LOAD;
`else
          state_nxt = S_LOAD;
`endif
        end
      end
      S_LOAD: begin
        bus.busy  = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.busy     = 1'b1;
        bus.div_nrst = 1'b1;
        if (cnt == LAST) state_nxt = S_FIX;
      end
      S_FIX: begin
        bus.busy  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef DIV_ZERO_TRAP_EN
  logic div_zero_r;
  assign bus.div_zero = div_zero_r;
`else
  assign bus.div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sq      <= 1'b0;
      sr      <= 1'b0;
      q_cap   <= '0;
      r_cap   <= '0;
      lo_r    <= '0;
      hi_r    <= '0;
      div_q_r <= '0;
      div_m_r <= '0;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_r <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sq      <= a_neg ^ b_neg;
            sr      <= a_neg;
            div_q_r <= a_neg ? -bus.a : bus.a;
            div_m_r <= b_neg ? -bus.b : bus.b;
`ifdef DIV_ZERO_TRAP_EN
            // The trap returns the raw dividend and never releases the core
            if (b_zero) begin
              lo_r       <= '1;
              hi_r       <= bus.a;
              div_zero_r <= 1'b1;
            end
`endif
          end
        end
        S_LOAD: cnt <= '0;
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            q_cap <= bus.core_q;
            r_cap <= bus.core_r;
          end
        end
        S_FIX: begin
          lo_r <= sq ? -q_cap : q_cap;
          hi_r <= sr ? -r_cap : r_cap;
`ifdef DIV_ZERO_TRAP_EN
          div_zero_r <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.lo    = lo_r;
  assign bus.hi    = hi_r;
  assign bus.div_q = div_q_r;
  assign bus.div_m = div_m_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard testbench for div_sequencer with a behavioural DIV core model that is valid only after its latency.
module tb_div_sequencer;
  localparam int W = 32;
  localparam int L = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_sequencer_if #(.DATA_WIDTH(W)) bus ();

  div_sequencer #(.DATA_WIDTH(W), .DIV_LATENCY(L)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // DIV core model: counts cycles while out of reset and returns garbage until the latency has elapsed
  int mcnt = 0;
  always @(posedge clk) mcnt <= bus.div_nrst ? mcnt + 1 : 0;
  assign bus.core_q = (bus.div_nrst && mcnt >= L - 1) ?
                      ((bus.div_m == '0) ? '1 : bus.div_q / bus.div_m) : 32'hDEAD_BEEF;
  assign bus.core_r = (bus.div_nrst && mcnt >= L - 1) ?
                      ((bus.div_m == '0) ? bus.div_q : bus.div_q % bus.div_m) : 32'hDEAD_BEEF;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", {31'b0, bus.done}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("lo", bus.lo, e.lo);
        chk("hi", bus.hi, e.hi);
        chk("div_zero", {31'b0, bus.div_zero}, {31'b0, e.dz});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b, output int e);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = sg;
    bus.a         = a;
    bus.b         = b;
    @(posedge clk);
    #1;
    e             = cyc;
    bus.start     = 1'b0;
    bus.signed_op = ~sg;
    bus.a         = 32'h1234_5678;
    bus.b         = 32'h0;
  endtask

  task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi, input logic exp_dz,
                        input logic [W-1:0] exp_dq, input logic [W-1:0] exp_dm, input int glitch);
    int   e;
    int   dl;
    int   k;
    int   busy_err;
    int   nrst_err;
    logic trap;
    trap = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    trap = (b == '0);
`endif
    dl = trap ? 1 : L + 3;
    busy_err = 0;
    nrst_err = 0;
    issue(sg, a, b, e);
    sbq.push_back('{exp_lo, exp_hi, exp_dz, e + dl - 1});
    k = 0;
    while (k <= dl) begin
      @(negedge clk);
      k = cyc - e + 1;
      if (bus.busy !== (!trap && k >= 1 && k <= L + 2)) busy_err++;
      if (bus.div_nrst !== (!trap && k >= 2 && k <= L + 1)) nrst_err++;
      if (k == 1 && !trap) begin
        chk("div_q", bus.div_q, exp_dq);
        chk("div_m", bus.div_m, exp_dm);
      end
      if (glitch != 0 && k == glitch) begin
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("busy_window_errors", busy_err, 0);
    chk("nrst_window_errors", nrst_err, 0);
    k = 0;
    while (sbq.size() != 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("completion_pending", sbq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   e;
    logic trap_dz;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_nrst", {31'b0, bus.div_nrst}, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_div_q", bus.div_q, 32'd0);
    chk("rst_div_m", bus.div_m, 32'd0);
    chk("rst_div_zero", {31'b0, bus.div_zero}, 32'd0);
    rst = 1'b0;

    run_op(1'b0, 32'd7, 32'd3, 32'd2, 32'd1, 1'b0, 32'd7, 32'd3, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'd7, 32'd3, 0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd1, 1'b0, 32'd7, 32'd3, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFF, 1'b0, 32'd7, 32'd3, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32'h8000_0000, 32'd1, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 32'hFFFF_FFFF, 32'h10, 0);

    trap_dz = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    trap_dz = 1'b1;
`endif
    run_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, trap_dz, 32'd5, 32'd0, 0);
    run_op(1'b0, 32'd6, 32'd2, 32'd3, 32'd0, 1'b0, 32'd6, 32'd2, 0);

    // A second request during RUN must be dropped
    run_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 32'd9, 32'd4, 10);
    repeat (45) @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse
    issue(1'b0, 32'd100, 32'd3, e);
    while (cyc - e + 1 < 19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_nrst", {31'b0, bus.div_nrst}, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_busy_later", {31'b0, bus.busy}, 32'd0);
    run_op(1'b0, 32'd8, 32'd2, 32'd4, 32'd0, 1'b0, 32'd8, 32'd2, 0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
